// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: position counters, de/hsync/vsync, frame strobe and frame counter
//
// Purpose: walks a raster of H_TOTAL x V_TOTAL pixels, one pixel per enabled clock,
// and presents registered timing flags that all describe the presented (hpos, vpos).
//
// Ports:
//   pixel_clk  in   pixel clock, all state changes on its rising edge
//   rst        in   asynchronous active-high reset
//   en         in   count enable, advances one pixel per clock when high
//   hpos       out  12-bit signed horizontal position, 0..H_TOTAL-1 (never negative)
//   vpos       out  12-bit signed vertical position, 0..V_TOTAL-1 (never negative)
//   de         out  active-video flag
//   hsync      out  horizontal sync at HS_POL level
//   vsync      out  vertical sync at VS_POL level
//   fsync      out  one-cycle strobe at (0, VRES), start of vertical blanking
//   frame_cnt  out  completed frames, modulo 2^16
module video_timing_gen #(
  parameter int HRES   = 1280,
  parameter int VRES   = 720,
  parameter int H_FP   = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20,
  parameter int HS_POL = 1,
  parameter int VS_POL = 1
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               en,
  output logic signed [11:0] hpos,
  output logic signed [11:0] vpos,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               fsync,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL = HRES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = VRES + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_params
      $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 2047");
    end
  endgenerate

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(HRES);
  localparam logic [10:0] V_ACT    = 11'(VRES);
  localparam logic [10:0] HS_START = 11'(HRES + H_FP);
  localparam logic [10:0] HS_END   = 11'(HRES + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(VRES + V_FP);
  localparam logic [10:0] VS_END   = 11'(VRES + V_FP + V_SYNC);
  localparam logic        HS_ON    = (HS_POL != 0);
  localparam logic        VS_ON    = (VS_POL != 0);

  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        fsync_q, fsync_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  // Reset parks the counters on the last pixel so the first enabled clock lands
  // on (0,0); this flag keeps that first wrap from counting as a completed frame.
  logic        started_q, started_d;
  logic        h_wrap;

  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    de_d        = de_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    fsync_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    started_d   = started_q;
    h_wrap      = (h_q == H_LAST);

    if (en) begin
      started_d = 1'b1;
      h_d       = h_wrap ? 11'd0 : h_q + 11'd1;
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
      end
      if (h_wrap && (v_q == V_LAST) && started_q) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      // Flags are decoded from the next position so they register alongside it.
      de_d    = (h_d < H_ACT) && (v_d < V_ACT);
      hsync_d = ((h_d >= HS_START) && (h_d < HS_END)) ? HS_ON : ~HS_ON;
      vsync_d = ((v_d >= VS_START) && (v_d < VS_END)) ? VS_ON : ~VS_ON;
      fsync_d = (h_d == 11'd0) && (v_d == V_ACT);
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_q         <= H_LAST;
      v_q         <= V_LAST;
      de_q        <= 1'b0;
      hsync_q     <= ~HS_ON;
      vsync_q     <= ~VS_ON;
      fsync_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
      started_q   <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      fsync_q     <= fsync_d;
      frame_cnt_q <= frame_cnt_d;
      started_q   <= started_d;
    end
  end

  assign hpos      = {1'b0, h_q};
  assign vpos      = {1'b0, v_q};
  assign de        = de_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign fsync     = fsync_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen on a scaled-down raster
module tb_video_timing_gen;

  // Scaled raster: 60 x 30 pixels, frame of 1800 clocks; vsync active-low.
  localparam int HRES = 40, H_FP = 6, H_SYNC = 4, H_BP = 10;
  localparam int VRES = 20, V_FP = 2, V_SYNC = 3, V_BP = 5;
  localparam int HT = HRES + H_FP + H_SYNC + H_BP;
  localparam int VT = VRES + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;
  localparam bit HS_POL_B = 1'b1;
  localparam bit VS_POL_B = 1'b0;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en  = 1'b0;
  logic signed [11:0] hpos, vpos;
  logic               de, hsync, vsync, fsync;
  logic [15:0]        frame_cnt;

  int total  = 0;
  int passed = 0;

  video_timing_gen #(
    .HRES(HRES), .VRES(VRES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .HS_POL(1), .VS_POL(0)
  ) dut (
    .pixel_clk(clk), .rst(rst), .en(en), .hpos(hpos), .vpos(vpos), .de(de),
    .hsync(hsync), .vsync(vsync), .fsync(fsync), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: the raster position is purely a function of how many enabled clocks
  // have elapsed since reset.
  int n       = 0;
  bit last_en = 1'b0;
  int fc_base = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n       <= 0;
      last_en <= 1'b0;
    end else begin
      if (en) n <= n + 1;
      last_en <= en;
    end
  end

  bit check_on = 1'b0;
  bit stats_on = 1'b0;
  int fs_cnt = 0, fs_h = -1, fs_v = -1;
  int de0_cnt = 0, hs0_cnt = 0, hs0_first = -1;
  int vs_cnt = 0, vs_h = -1, vs_v = -1, blank_de = 0;

  always @(negedge clk) begin
    int p, eh, ev, efc;
    bit ede, ehs, evs, efs;
    if (check_on) begin
      if (n == 0) begin
        eh = HT - 1; ev = VT - 1; ede = 0;
        ehs = ~HS_POL_B; evs = ~VS_POL_B; efs = 0; efc = 0;
      end else begin
        p   = (n - 1) % FRAME;
        eh  = p % HT;
        ev  = p / HT;
        ede = (eh < HRES) && (ev < VRES);
        ehs = (eh >= HRES + H_FP && eh < HRES + H_FP + H_SYNC) ? HS_POL_B : ~HS_POL_B;
        evs = (ev >= VRES + V_FP && ev < VRES + V_FP + V_SYNC) ? VS_POL_B : ~VS_POL_B;
        efs = last_en && eh == 0 && ev == VRES;
        efc = (fc_base + (n - 1) / FRAME) % 65536;
      end
      chk("model_hpos", int'(hpos), eh);
      chk("model_vpos", int'(vpos), ev);
      chk("model_de", int'(de), int'(ede));
      chk("model_hsync", int'(hsync), int'(ehs));
      chk("model_vsync", int'(vsync), int'(evs));
      chk("model_fsync", int'(fsync), int'(efs));
      chk("model_frame_cnt", int'(frame_cnt), efc);
    end
    if (stats_on) begin
      if (fsync) begin fs_cnt++; fs_h = int'(hpos); fs_v = int'(vpos); end
      if (vpos == 0) begin
        de0_cnt += int'(de);
        if (hsync == HS_POL_B) begin
          hs0_cnt++;
          if (hs0_first < 0) hs0_first = int'(hpos);
        end
      end
      if (vsync == VS_POL_B) begin
        if (vs_cnt == 0) begin vs_h = int'(hpos); vs_v = int'(vpos); end
        vs_cnt++;
      end
      if (vpos >= VRES && de) blank_de++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pos(input int h, input int v, input string name);
    int k = 0;
    while (!(hpos == h && vpos == v) && k < 4000) begin
      step();
      k++;
    end
    chk(name, int'(hpos == h && vpos == v), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cnt;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) step();
    check_on = 1'b1;
    chk("rst_hpos", int'(hpos), 59);
    chk("rst_vpos", int'(vpos), 29);
    chk("rst_de", int'(de), 0);
    chk("rst_hsync", int'(hsync), 0);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_fsync", int'(fsync), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);

    // First frame with statistics.
    rst = 1'b0;
    en  = 1'b1;
    stats_on = 1'b1;
    step();
    chk("first_hpos", int'(hpos), 0);
    chk("first_vpos", int'(vpos), 0);
    chk("first_de", int'(de), 1);
    chk("first_frame_cnt", int'(frame_cnt), 0);
    repeat (FRAME - 1) step();
    stats_on = 1'b0;
    chk("frame_end_hpos", int'(hpos), 59);
    chk("frame_end_vpos", int'(vpos), 29);
    chk("frame1_frame_cnt_before_wrap", int'(frame_cnt), 0);
    step();
    chk("frame2_hpos", int'(hpos), 0);
    chk("frame2_vpos", int'(vpos), 0);
    chk("frame2_frame_cnt", int'(frame_cnt), 1);
    chk("fsync_count", fs_cnt, 1);
    chk("fsync_hpos", fs_h, 0);
    chk("fsync_vpos", fs_v, 20);
    chk("line0_de_count", de0_cnt, 40);
    chk("line0_hsync_count", hs0_cnt, 4);
    chk("line0_hsync_first", hs0_first, 46);
    chk("vsync_count", vs_cnt, 180);
    chk("vsync_first_hpos", vs_h, 0);
    chk("vsync_first_vpos", vs_v, 22);
    chk("blank_de_count", blank_de, 0);

    // Line wrap 59 -> 0 with vpos 0 -> 1 (frame 2 starts at (0,0)).
    repeat (HT - 1) step();
    chk("wrap_pre_hpos", int'(hpos), 59);
    step();
    chk("wrap_hpos", int'(hpos), 0);
    chk("wrap_vpos", int'(vpos), 1);

    // Hold with en low.
    wait_pos(25, 12, "reach_hold_pos");
    en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      cnt += int'(fsync);
    end
    chk("hold_fsync_count", cnt, 0);
    chk("hold_hpos", int'(hpos), 25);
    chk("hold_vpos", int'(vpos), 12);
    en = 1'b1;
    step();
    chk("resume_hpos", int'(hpos), 26);
    chk("resume_vpos", int'(vpos), 12);

    // Drop en in the fsync cycle: strobe must not repeat while held.
    k = 0;
    while (!fsync && k < 4000) begin
      step();
      k++;
    end
    chk("fsync_seen", int'(fsync), 1);
    chk("fsync_at_hpos", int'(hpos), 0);
    chk("fsync_at_vpos", int'(vpos), 20);
    en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(fsync);
    end
    chk("fsync_hold_count", cnt, 0);
    chk("fsync_hold_vpos", int'(vpos), 20);
    en = 1'b1;

    // Asynchronous reset mid-frame.
    wait_pos(35, 15, "reach_reset_pos");
    chk("pre_reset_frame_cnt", int'(frame_cnt), 2);
    rst = 1'b1;
    #1;
    chk("async_rst_hpos", int'(hpos), 59);
    chk("async_rst_vpos", int'(vpos), 29);
    chk("async_rst_de", int'(de), 0);
    chk("async_rst_vsync", int'(vsync), 1);
    chk("async_rst_fsync", int'(fsync), 0);
    chk("async_rst_frame_cnt", int'(frame_cnt), 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      cnt += int'(fsync);
    end
    chk("rst_fsync_count", cnt, 0);
    rst = 1'b0;
    step();
    chk("post_rst_hpos", int'(hpos), 0);
    chk("post_rst_vpos", int'(vpos), 0);
    chk("post_rst_de", int'(de), 1);
    chk("post_rst_frame_cnt", int'(frame_cnt), 0);

    // Frame counter wrap from 65535.
    wait_pos(10, 5, "reach_force_pos");
    force dut.frame_cnt_q = 16'hFFFF;
    fc_base = 65535 - ((n - 1) / FRAME);
    step();
    release dut.frame_cnt_q;
    wait_pos(59, 29, "reach_wrap_pos");
    chk("pre_wrap_frame_cnt", int'(frame_cnt), 65535);
    step();
    chk("wrap_frame_cnt", int'(frame_cnt), 0);
    chk("wrap_frame_hpos", int'(hpos), 0);
    repeat (5) step();

    check_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter HRES, default 1280, meaning active pixels per line.
REQ-002 The block SHALL have parameter VRES, default 720, meaning active lines per frame.
REQ-003 The block SHALL have parameters H_FP 110, H_SYNC 40, H_BP 220, meaning horizontal front porch, sync and back porch widths in pixels.
REQ-004 The block SHALL have parameters V_FP 5, V_SYNC 5, V_BP 20, meaning vertical front porch, sync and back porch heights in lines.
REQ-005 The block SHALL have parameters HS_POL 1 and VS_POL 1, meaning the asserted level of hsync and vsync.
REQ-006 pixel_clk  input  1  pixel clock; all state SHALL change on its rising edge only.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 en  input  1  count enable; when high, the timing advances one pixel per clock.
REQ-009 hpos  output  12 signed  current horizontal position, 0..H_TOTAL-1.
REQ-010 vpos  output  12 signed  current vertical position, 0..V_TOTAL-1.
REQ-011 de  output  1  active-video flag for the current (hpos, vpos).
REQ-012 hsync, vsync  output  1 each  sync pulses at the HS_POL/VS_POL level.
REQ-013 fsync  output  1  one-cycle frame-update strobe for downstream object and ball stages.
REQ-014 frame_cnt  output  16  count of completed frames, modulo 2^16.

Function
REQ-015 H_TOTAL SHALL equal HRES+H_FP+H_SYNC+H_BP (default 1650), and V_TOTAL SHALL equal VRES+V_FP+V_SYNC+V_BP (default 750).
REQ-016 When en is high, hpos SHALL increment by 1 per clock and wrap from H_TOTAL-1 to 0.
REQ-017 vpos SHALL increment by 1 only on the hpos wrap, and SHALL wrap from V_TOTAL-1 to 0 on the hpos wrap at vpos=V_TOTAL-1.
REQ-018 When en is low, every register SHALL hold its value, except fsync, which SHALL be 0.
REQ-019 All outputs SHALL be registered, and each SHALL describe the same cycle as the hpos/vpos values currently presented; there is no pipeline skew between outputs.
REQ-020 de SHALL be 1 only when hpos<HRES and vpos<VRES.
REQ-021 hsync SHALL be asserted when HRES+H_FP <= hpos < HRES+H_FP+H_SYNC (default 1390..1429), for every line including blanking lines.
REQ-022 vsync SHALL be asserted for all hpos when VRES+V_FP <= vpos < VRES+V_FP+V_SYNC (default 725..729).
REQ-023 fsync SHALL be 1 for exactly one clock per frame, in the cycle where hpos=0 and vpos=VRES, so that downstream position updates land in vertical blanking.
REQ-024 If en drops in the fsync cycle, fsync SHALL stay high for that cycle only and SHALL NOT repeat while the counters are held at (0, VRES).
REQ-025 frame_cnt SHALL increment on the transition from (H_TOTAL-1, V_TOTAL-1) to (0,0), and SHALL wrap from 65535 to 0.
REQ-026 Position arithmetic SHALL use unsigned counters internally; hpos and vpos SHALL carry those values zero-extended into the 12-bit signed ports, so they are never negative.
REQ-027 Parameter sets with H_TOTAL>2047 or V_TOTAL>2047 SHALL be rejected at elaboration.

Reset
REQ-028 While rst is high, outputs SHALL be forced asynchronously to: hpos=H_TOTAL-1, vpos=V_TOTAL-1, de=0, hsync=!HS_POL, vsync=!VS_POL, fsync=0, frame_cnt=0.
REQ-029 The first enabled clock after rst is released SHALL present (0,0) with de=1 and SHALL NOT increment frame_cnt.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no fsync emitted.

Verification
REQ-031 Release reset with en=1 and run 1650*750 clocks: the first cycle shows hpos=0, vpos=0, de=1; exactly one fsync occurs at (0,720); frame_cnt=1 at the next (0,0).
REQ-032 Line check on vpos=0: de is high for 1280 clocks, hsync is high over 1390..1429 (40 clocks), and hpos wraps 1649->0 while vpos steps 0->1.
REQ-033 Frame check: vsync is high for 5*1650=8250 clocks starting at (0,725), and de stays 0 for all vpos>=720.
REQ-034 Hold en=0 for 100 clocks at (500,300), then set en=1: counters are frozen and fsync=0 during the hold; resume at (501,300).
REQ-035 Assert rst at (800,400) mid-frame: outputs take their reset values asynchronously with no fsync, and after release the next enabled clock shows (0,0).
REQ-036 Force frame_cnt to 65535 and complete one frame: frame_cnt wraps to 0.
